memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Shares one memory port between the instruction-fetch and data requesters of the core.
//  Its single master port drives the fast side of the clock-crossing bridge.
//  Keeps exactly one transaction outstanding on the shared port and buffers one pending request per requester.
//  Routes each response back to the requester that owns it.
// PARAMETERS
//  timeout  1024  cycles to wait for memory_ready after launch; 0 = never time out
// PORTS
//  clock           in   1   system clock; all logic on posedge
//  reset           in   1   synchronous, active-high
//  imemory_valid   in   1   fetch request pulse (1 cycle)
//  imemory_addr    in   32  fetch address
//  imemory_rdata   out  32  fetch read data, valid with imemory_ready
//  imemory_ready   out  1   fetch completion pulse
//  dmemory_valid   in   1   data request pulse (1 cycle)
//  dmemory_addr    in   32  data address
//  dmemory_wdata   in   32  write data
//  dmemory_wstrb   in   4   byte strobes; 0 = read
//  dmemory_rdata   out  32  data read data, valid with dmemory_ready
//  dmemory_ready   out  1   data completion pulse
//  memory_valid    out  1   launch pulse to shared port
//  memory_instr    out  1   1 = fetch transaction, 0 = data transaction
//  memory_addr     out  32  shared-port address
//  memory_wdata    out  32  shared-port write data
//  memory_wstrb    out  4   shared-port strobes
//  memory_rdata    in   32  shared-port read data
//  memory_ready    in   1   shared-port completion pulse
//  overrun_error   out  1   sticky: request arrived on a port with one already pending or in flight
//  timeout_error   out  1   sticky: a transaction hit the timeout
// BEHAVIOUR
//  - Reset: state IDLE, both pending slots empty, timer 0. Every output is 0, including both sticky flags.
//  - Capture: a *_valid pulse is stored in that port's pending slot.
//    - If the port already has a pending or in-flight request, the new request is dropped and overrun_error is set.
//    - A fetch request is stored as instr=1, wdata=0, wstrb=0.
//  - Requester contract: at most one request outstanding per port. A new request may be issued in the same cycle as that port's *_ready.
//  - State machine: IDLE -> BUSY on launch; BUSY -> IDLE on memory_ready or timeout.
//  - IDLE:
//    - If any slot is pending, select a winner and load the memory_* output registers.
//    - memory_valid is high for exactly 1 cycle; the winner's slot is cleared and owner := winner.
//    - Latency: request pulse in cycle t -> memory_valid in cycle t+1 at the earliest.
//  - BUSY:
//    - memory_valid=0. memory_addr/instr/wdata/wstrb hold their launched values until the next launch.
//    - Requests that arrive while BUSY are captured into the pending slots.
//  - Completion: memory_ready=1 in BUSY copies memory_rdata to the owner's *_rdata and pulses the owner's *_ready in the same cycle (combinational).
//    - The other port's ready stays 0.
//    - State -> IDLE. The next pending request launches in the following cycle, so there is one idle cycle between transactions.
//  - memory_ready while IDLE (stale, or arriving after reset) is ignored: no requester ready, no state change.
//  - Timeout (timeout>0): the timer counts BUSY cycles.
//    - When the timer reaches timeout with no memory_ready, the owner gets *_ready=1 with rdata=0, timeout_error is set, and state -> IDLE.
//    - If memory_ready arrives in that same cycle, it wins: normal data is returned and no error is flagged.
//  - Simultaneous capture of both ports in one cycle is legal; both slots fill.
//  - Reset mid-transaction:
//    - Pending slots, owner and flags clear.
//    - No *_ready is produced for the aborted transaction.
//    - Requesters must reissue.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//    - On a tie, the port that did not win the previous launch wins.
//    - The last-winner register resets to "data", so the first tie goes to fetch.
//  ARB_ROUND_ROBIN_EN undefined: fixed priority, data always beats fetch on a tie.
// TESTING
//  - Single fetch: imemory_valid, addr=0x100 at t=0 -> memory_valid, instr=1, addr=0x100 at t=1.
//    - memory_ready, rdata=0xDEADBEEF at t=4 -> imemory_ready=1, imemory_rdata=0xDEADBEEF at t=4; dmemory_ready stays 0.
//  - Tie: both valid at t=0 (d: addr=0x200, wstrb=0xF, wdata=0x55).
//    - Without the macro: the data write launches first at t=1; after its ready, the fetch launches 1 cycle later.
//    - With ARB_ROUND_ROBIN_EN: the fetch launches first.
//  - Overrun: dmemory_valid twice while the first is in flight -> the second is dropped, overrun_error=1, a single dmemory_ready is returned.
//  - Timeout: timeout=8, launch with no memory_ready -> at the 8th BUSY cycle the owner gets ready with rdata=0, timeout_error=1, state IDLE.
//  - Reset in BUSY with the other slot pending, then memory_ready=1 after reset -> no requester ready, no launch, all outputs 0.
//  - Back-to-back: dmemory_valid in the same cycle as its own dmemory_ready -> the next launch follows 1 cycle later with the new address.

Source files
------------

// File: rtl/memory_arbiter.sv
// Shares one memory port between fetch and data requesters; request -> memory_valid next cycle, completion returned combinationally.
// No backpressure: one pending slot per port, extra requests are dropped with a sticky overrun flag. ARB_ROUND_ROBIN_EN selects round-robin ties.
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_imemory_valid,
  input  logic [31:0] i_imemory_addr,
  output logic [31:0] o_imemory_rdata,
  output logic        o_imemory_ready,
  input  logic        i_dmemory_valid,
  input  logic [31:0] i_dmemory_addr,
  input  logic [31:0] i_dmemory_wdata,
  input  logic [3:0]  i_dmemory_wstrb,
  output logic [31:0] o_dmemory_rdata,
  output logic        o_dmemory_ready,
  output logic        o_memory_valid,
  output logic        o_memory_instr,
  output logic [31:0] o_memory_addr,
  output logic [31:0] o_memory_wdata,
  output logic [3:0]  o_memory_wstrb,
  input  logic [31:0] i_memory_rdata,
  input  logic        i_memory_ready,
  output logic        o_overrun_error,
  output logic        o_timeout_error
);

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state, w_state_nxt;
  req_t        r_ireq, r_dreq, r_mreq;
  req_t        w_inew, w_dnew, w_isel, w_dsel, w_win_req;
  logic        r_ipend, r_dpend, r_owner_i, r_mvalid, r_ovr, r_tout;
  logic [31:0] r_timer;
  logic        w_done, w_launch, w_tmo;
  logic        w_iflight, w_dflight, w_iovr, w_dovr, w_icap, w_dcap;
  logic        w_icand, w_dcand, w_win_i;
  logic [31:0] w_rdata;

  assign w_inew = {1'b1, i_imemory_addr, 32'd0, 4'd0};
  assign w_dnew = {1'b0, i_dmemory_addr, i_dmemory_wdata, i_dmemory_wstrb};

  assign w_tmo = (TIMEOUT != 0) && (r_timer == 32'(TIMEOUT - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_launch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_icand || w_dcand) begin
          w_launch    = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        // memory_ready takes precedence over a coincident timeout
        if (!i_reset && (i_memory_ready || w_tmo)) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A port completing this cycle may already issue its next request
  assign w_iflight = (r_state == S_BUSY) &&  r_owner_i && !w_done;
  assign w_dflight = (r_state == S_BUSY) && !r_owner_i && !w_done;
  assign w_iovr    = i_imemory_valid && (r_ipend || w_iflight);
  assign w_dovr    = i_dmemory_valid && (r_dpend || w_dflight);
  assign w_icap    = i_imemory_valid && !w_iovr;
  assign w_dcap    = i_dmemory_valid && !w_dovr;
  assign w_icand   = r_ipend || w_icap;
  assign w_dcand   = r_dpend || w_dcap;
  assign w_isel    = r_ipend ? r_ireq : w_inew;
  assign w_dsel    = r_dpend ? r_dreq : w_dnew;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_i;
  assign w_win_i = w_icand && (!w_dcand || !r_last_i);
  always_ff @(posedge i_clock) begin
    if (i_reset)       r_last_i <= 1'b0;
    else if (w_launch) r_last_i <= w_win_i;
  end
`else
  assign w_win_i = w_icand && !w_dcand;
`endif

  assign w_win_req = w_win_i ? w_isel : w_dsel;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ipend   <= 1'b0;
      r_dpend   <= 1'b0;
      r_ireq    <= '0;
      r_dreq    <= '0;
      r_mreq    <= '0;
      r_mvalid  <= 1'b0;
      r_owner_i <= 1'b0;
      r_timer   <= '0;
      r_ovr     <= 1'b0;
      r_tout    <= 1'b0;
    end else begin
      if (w_icap) r_ireq <= w_inew;
      if (w_dcap) r_dreq <= w_dnew;
      r_ipend  <= (r_ipend | w_icap) & ~(w_launch &  w_win_i);
      r_dpend  <= (r_dpend | w_dcap) & ~(w_launch & ~w_win_i);
      r_mvalid <= w_launch;
      if (w_launch) begin
        r_mreq    <= w_win_req;
        r_owner_i <= w_win_i;
        r_timer   <= '0;
      end else if (r_state == S_BUSY) begin
        r_timer <= r_timer + 32'd1;
      end
      if (w_iovr || w_dovr)         r_ovr  <= 1'b1;
      if (w_done && !i_memory_ready) r_tout <= 1'b1;
    end
  end

  assign w_rdata         = i_memory_ready ? i_memory_rdata : 32'd0;
  assign o_imemory_ready = w_done &&  r_owner_i;
  assign o_dmemory_ready = w_done && !r_owner_i;
  assign o_imemory_rdata = o_imemory_ready ? w_rdata : 32'd0;
  assign o_dmemory_rdata = o_dmemory_ready ? w_rdata : 32'd0;

  assign o_memory_valid  = r_mvalid;
  assign o_memory_instr  = r_mreq.instr;
  assign o_memory_addr   = r_mreq.addr;
  assign o_memory_wdata  = r_mreq.wdata;
  assign o_memory_wstrb  = r_mreq.wstrb;
  assign o_overrun_error = r_ovr;
  assign o_timeout_error = r_tout;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter against a transaction-level reference model.
module tb_memory_arbiter;
  localparam int TMO = 8;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } treq_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv, dv, mr;
  logic [31:0] ia, da, dw, mrd;
  logic [3:0]  ds;
  logic [31:0] ird, drd, ma, mw;
  logic        irdy, drdy, mv, mi, ovr, tmo;
  logic [3:0]  ms;

  always #5 clk = ~clk;

  memory_arbiter #(.TIMEOUT(TMO)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_imemory_valid(iv), .i_imemory_addr(ia),
    .o_imemory_rdata(ird), .o_imemory_ready(irdy),
    .i_dmemory_valid(dv), .i_dmemory_addr(da), .i_dmemory_wdata(dw), .i_dmemory_wstrb(ds),
    .o_dmemory_rdata(drd), .o_dmemory_ready(drdy),
    .o_memory_valid(mv), .o_memory_instr(mi), .o_memory_addr(ma),
    .o_memory_wdata(mw), .o_memory_wstrb(ms),
    .i_memory_rdata(mrd), .i_memory_ready(mr),
    .o_overrun_error(ovr), .o_timeout_error(tmo)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: port 0 = fetch, port 1 = data
  bit    pend[2];
  treq_t preq[2];
  bit    outst[2];
  int    owner, age, resp_at, last;
  bit    e_mv, e_ovr, e_tmo;
  treq_t e_m;

  task automatic model_clear();
    pend[0] = 0; pend[1] = 0; outst[0] = 0; outst[1] = 0;
    owner = -1; age = 0; resp_at = 0; last = 1;
    e_mv = 0; e_m = '0; e_ovr = 0; e_tmo = 0;
  endtask

  initial begin
    bit    v[2];
    treq_t nreq[2];
    bit    done, free, both;
    int    w;
    rst = 1; iv = 0; dv = 0; mr = 0; ia = 0; da = 0; dw = 0; ds = 0; mrd = 0;
    model_clear();
    repeat (2) @(posedge clk);
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(posedge clk);
      #1;
      rst = (cyc < 3) || ($urandom_range(0, 299) == 0);
      mrd = $urandom;
      if (owner >= 0) mr = (age == resp_at);
      else            mr = ($urandom_range(0, 9) == 0);
      done = !rst && (owner >= 0) && (mr || age == TMO);
      for (int p = 0; p < 2; p++) begin
        if (!outst[p] || (done && owner == p)) v[p] = ($urandom_range(0, 9) < 3);
        else                                   v[p] = ($urandom_range(0, 39) == 0);
      end
      nreq[0] = {1'b1, $urandom(), 32'd0, 4'd0};
      nreq[1] = {1'b0, $urandom(), $urandom(), 4'($urandom_range(0, 15))};
      iv = v[0]; ia = nreq[0].addr;
      dv = v[1]; da = nreq[1].addr; dw = nreq[1].wdata; ds = nreq[1].wstrb;

      @(negedge clk);
      check("mem_valid", 32'(mv), 32'(e_mv));
      check("mem_instr", 32'(mi), 32'(e_m.instr));
      check("mem_addr",  ma, e_m.addr);
      check("mem_wdata", mw, e_m.wdata);
      check("mem_wstrb", 32'(ms), 32'(e_m.wstrb));
      check("overrun",   32'(ovr), 32'(e_ovr));
      check("timeout",   32'(tmo), 32'(e_tmo));
      check("i_ready",   32'(irdy), 32'(done && owner == 0));
      check("d_ready",   32'(drdy), 32'(done && owner == 1));
      if (done && owner == 0) check("i_rdata", ird, mr ? mrd : 32'd0);
      if (done && owner == 1) check("d_rdata", drd, mr ? mrd : 32'd0);

      if (rst) begin
        model_clear();
      end else begin
        free = (owner < 0);
        for (int p = 0; p < 2; p++) begin
          if (done && owner == p) outst[p] = 0;
          if (v[p]) begin
            if (pend[p] || (owner == p && !done)) e_ovr = 1;
            else begin
              pend[p] = 1; preq[p] = nreq[p]; outst[p] = 1;
            end
          end
        end
        if (done) begin
          if (!mr) e_tmo = 1;
          owner = -1;
        end else if (owner >= 0) begin
          age++;
        end
        e_mv = 0;
        if (free && (pend[0] || pend[1])) begin
          both = pend[0] && pend[1];
`ifdef ARB_ROUND_ROBIN_EN
          if (both) w = (last == 1) ? 0 : 1;
`else
          if (both) w = 1;
`endif
          else w = pend[0] ? 0 : 1;
          e_mv = 1; e_m = preq[w]; pend[w] = 0;
          owner = w; age = 1; last = w;
          resp_at = $urandom_range(0, 10);
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
